// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decode-side control, instruction-memory port and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
   parameter int ISIZE = 16,
   parameter int DSIZE = 16
);
   logic             stall;
   logic             redirect;
   logic [ISIZE-1:0] redirect_pc;
   logic [ISIZE-1:0] imem_addr;
   logic [DSIZE-1:0] imem_rdata;
   logic [ISIZE-1:0] pc_id;
   logic [DSIZE-1:0] inst_id;
   logic             valid_id;
   logic [15:0]      bubble_cnt;

   modport master (
      input  stall, redirect, redirect_pc, imem_rdata,
      output imem_addr, pc_id, inst_id, valid_id, bubble_cnt
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_rdata,
      input  imem_addr, pc_id, inst_id, valid_id, bubble_cnt
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a 1-cycle-latency instruction memory,
// realigns returned words with their PCs, replays under stall and squashes on redirect.
module fetch_unit #(
   parameter int               ISIZE    = 16,
   parameter int               DSIZE    = 16,
   parameter logic [ISIZE-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [ISIZE-1:0] pc_fetch;
   logic [ISIZE-1:0] pc_req;
   logic [ISIZE-1:0] pc_id;
   logic [DSIZE-1:0] inst_id;
   logic             valid_id;
   logic [15:0]      bubble_cnt;
   logic [ISIZE-1:0] imem_addr;

   // A stall replays pc_req; on the cycle a HOLD is released the replayed word is
   // being captured, so pc_fetch is already presented to avoid a bubble.
   always_comb begin
      imem_addr = pc_fetch;
      if (bus.redirect) begin
         imem_addr = bus.redirect_pc;
      end else if (bus.stall && state != IDLE) begin
         imem_addr = pc_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc_fetch   <= RESET_PC;
         pc_req     <= RESET_PC;
         pc_id      <= '0;
         inst_id    <= '0;
         valid_id   <= 1'b0;
         bubble_cnt <= '0;
      end else begin
         if (!valid_id && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end
         if (bus.redirect) begin
            valid_id <= 1'b0;
            pc_req   <= bus.redirect_pc;
            pc_fetch <= bus.redirect_pc + ISIZE'(1);
            state    <= RUN;
         end else begin
            case (state)
               IDLE: begin
                  valid_id <= 1'b0;
                  pc_req   <= pc_fetch;
                  pc_fetch <= pc_fetch + ISIZE'(1);
                  state    <= RUN;
               end
               RUN, HOLD: begin
                  if (bus.stall) begin
                     state <= HOLD;
                  end else begin
                     inst_id  <= bus.imem_rdata;
                     pc_id    <= pc_req;
                     valid_id <= 1'b1;
                     pc_req   <= pc_fetch;
                     pc_fetch <= pc_fetch + ISIZE'(1);
                     state    <= RUN;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.imem_addr  = imem_addr;
   assign bus.pc_id      = pc_id;
   assign bus.inst_id    = inst_id;
   assign bus.valid_id   = valid_id;
   assign bus.bubble_cnt = bubble_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect traffic,
// checked against an output-stream model (next PC to deliver, primed flag, bubble count).
module tb_fetch_unit;
   localparam int          ISIZE    = 16;
   localparam int          DSIZE    = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if #(.ISIZE(ISIZE), .DSIZE(DSIZE)) bus ();

   fetch_unit #(.ISIZE(ISIZE), .DSIZE(DSIZE), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [15:0] mem [0:65535];
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

   int passed = 0;
   int total  = 0;

   // Stream model: what decode should see, independent of how fetch is pipelined.
   logic        m_valid;
   logic [15:0] m_pc;
   logic [15:0] m_inst;
   logic [15:0] m_bub;
   logic [15:0] m_next;
   logic        m_primed;

   task automatic model_reset();
      m_valid = 1'b0; m_pc = '0; m_inst = '0; m_bub = '0;
      m_next = RESET_PC; m_primed = 1'b0;
   endtask

   task automatic step(input logic s, input logic r, input logic [15:0] t);
      bus.stall = s; bus.redirect = r; bus.redirect_pc = t;
      @(posedge clk);
      if (!m_valid && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
      if (r) begin
         m_valid = 1'b0; m_next = t; m_primed = 1'b1;
      end else if (!m_primed) begin
         m_primed = 1'b1;
      end else if (!s) begin
         m_valid = 1'b1; m_pc = m_next; m_inst = mem[m_next]; m_next = m_next + 16'd1;
      end
      #1;
   endtask

   function automatic logic [48:0] obs();
      return {bus.valid_id, bus.pc_id, bus.inst_id, bus.bubble_cnt};
   endfunction

   function automatic logic [48:0] mdl();
      return {m_valid, m_pc, m_inst, m_bub};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
      model_reset();
      #2;
      total++;
      if ({obs(), bus.imem_addr} !== {1'b0, 16'h0, 16'h0, 16'h0, RESET_PC})
         $display("FAIL reset_values: got %h expected %h", {obs(), bus.imem_addr},
                  {1'b0, 16'h0, 16'h0, 16'h0, RESET_PC});
      else passed++;
      @(posedge clk); #3;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL startup_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
      total++;
      if (obs() !== {1'b1, 16'h0000, 16'hA000, 16'd2})
         $display("FAIL first_valid: got %h expected %h", obs(), {1'b1, 16'h0000, 16'hA000, 16'd2});
      else passed++;
   endtask

   task automatic test_stream();
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL stream_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      #1;
      total++;
      if (bus.imem_addr !== m_next)
         $display("FAIL stall_addr_pre: got %h expected %h", bus.imem_addr, m_next);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL stall_hold_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
         total++;
         if (bus.imem_addr !== m_next)
            $display("FAIL stall_addr_%0d: got %h expected %h", k, bus.imem_addr, m_next);
         else passed++;
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL stall_release_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_redirect();
      step(1'b0, 1'b1, 16'h0040);
      total++;
      if (obs() !== mdl()) $display("FAIL redirect_bubble: got %h expected %h", obs(), mdl());
      else passed++;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL redirect_seq_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_redirect_stall();
      step(1'b1, 1'b1, 16'h0010);
      total++;
      if (obs() !== mdl()) $display("FAIL rs_squash: got %h expected %h", obs(), mdl());
      else passed++;
      step(1'b1, 1'b0, '0);
      total++;
      if ({obs(), bus.imem_addr} !== {mdl(), m_next})
         $display("FAIL rs_stalled: got %h expected %h", {obs(), bus.imem_addr}, {mdl(), m_next});
      else passed++;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL rs_deliver_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1, 16'hFFFE);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL wrap_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_random();
      logic s, r;
      logic [15:0] t;
      for (int k = 0; k < 400; k++) begin
         s = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 9) == 0);
         t = 16'($urandom);
         step(s, r, t);
         total++;
         if (obs() !== mdl()) $display("FAIL random_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1, 16'h0020);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0);
      total++;
      if (bus.pc_id !== 16'h0023) $display("FAIL mid_setup: got %h expected %h", bus.pc_id, 16'h0023);
      else passed++;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      total++;
      if ({obs(), bus.imem_addr} !== {1'b0, 16'h0, 16'h0, 16'h0, RESET_PC})
         $display("FAIL mid_reset_values: got %h expected %h", {obs(), bus.imem_addr},
                  {1'b0, 16'h0, 16'h0, 16'h0, RESET_PC});
      else passed++;
      @(posedge clk); #3;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (obs() !== mdl()) $display("FAIL mid_restart_%0d: got %h expected %h", k, obs(), mdl());
         else passed++;
      end
   endtask

   task automatic test_saturation();
      step(1'b0, 1'b1, 16'h0100);
      for (int k = 0; k < 65540; k++) step(1'b1, 1'b0, '0);
      total++;
      if (bus.bubble_cnt !== 16'hFFFF)
         $display("FAIL sat_reach: got %h expected %h", bus.bubble_cnt, 16'hFFFF);
      else passed++;
      step(1'b1, 1'b0, '0);
      total++;
      if (obs() !== mdl()) $display("FAIL sat_hold: got %h expected %h", obs(), mdl());
      else passed++;
      step(1'b0, 1'b0, '0);
      total++;
      if (obs() !== mdl()) $display("FAIL sat_release: got %h expected %h", obs(), mdl());
      else passed++;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'hA000 + 16'(i);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_wrap();
      test_random();
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
